// File: rtl/sd_cic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_cic_pkg
// Brief    : Shared constants, sizing helpers and comb FSM state type for the
//            sigma-delta CIC decimator.
// Revision : 1.0 - initial release
// ============================================================================
package sd_cic_pkg;

    localparam int c_N_DEFAULT = 3;
    localparam int c_R_DEFAULT = 64;

    // Register growth of an N-stage CIC at ratio R, plus sign and the +/-1 input
    function automatic int cic_width(input int n, input int r);
        return n * $clog2(r) + 2;
    endfunction

    // DC gain of the decimator, i.e. the full-scale output magnitude
    function automatic longint cic_gain(input int n, input int r);
        longint g;
        g = 1;
        for (int i = 0; i < n; i++) begin
            g = g * longint'(r);
        end
        return g;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COMB = 2'd1,
        ST_DONE = 2'd2
    } comb_state_t;

endpackage
`default_nettype wire

// File: rtl/sd_cic_if.sv
`default_nettype none
// ============================================================================
// Module   : sd_cic_if
// Brief    : Bitstream-in / PCM-out bundle of the CIC decimator. The master
//            side feeds bits and consumes samples; the slave side is the
//            decimator itself.
// Revision : 1.0 - initial release
// ============================================================================
interface sd_cic_if #(
    parameter int W = 20
);
    logic                enb;
    logic                in;
    logic signed [W-1:0] out;
    logic                out_valid;

    modport master (
        output enb,
        output in,
        input  out,
        input  out_valid
    );

    modport slave (
        input  enb,
        input  in,
        output out,
        output out_valid
    );
endinterface
`default_nettype wire

// File: rtl/sd_cic_integrator.sv
`default_nettype none
// ============================================================================
// Module   : sd_cic_integrator
// Brief    : One enabled accumulator stage. Wraps modulo 2^W on purpose: the
//            following comb differences cancel the wrap exactly.
// Revision : 1.0 - initial release
// ============================================================================
module sd_cic_integrator #(
    parameter int W = 20
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                i_en,
    input  wire logic signed [W-1:0] i_add,
    output logic signed [W-1:0]      o_acc
);

    logic signed [W-1:0] r_acc;

    // Accumulate on enable; two's-complement wrap is intentional
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + i_add;
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/sd_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module   : sd_cic_decimator
// Brief    : N-stage CIC decimator by R for a 1-bit sigma-delta stream.
//            Registered integrator chain at the bit rate, one shared
//            subtractor time-multiplexed over the N comb stages.
// Revision : 1.0 - initial release
// ============================================================================
module sd_cic_decimator
    import sd_cic_pkg::*;
#(
    parameter int N = c_N_DEFAULT,
    parameter int R = c_R_DEFAULT,
    parameter int W = cic_width(N, R)
) (
    input  wire logic clk,
    input  wire logic reset,
    sd_cic_if.slave   bus
);

    localparam int c_CW = $clog2(R);
    localparam int c_KW = (N > 1) ? $clog2(N) : 1;

    logic signed [W-1:0] w_step;
    logic signed [W-1:0] w_int [N];
    logic                w_capture;
    logic                w_comb_step;
    logic                w_emit;

    comb_state_t         r_state;
    comb_state_t         w_state_nxt;
    logic [c_CW-1:0]     r_cnt;
    logic [c_KW-1:0]     r_k;
    logic signed [W-1:0] r_x;
    logic signed [W-1:0] r_d [N];
    logic signed [W-1:0] r_out;
    logic                r_valid;

    // Bit 1 contributes +1, bit 0 contributes -1
    assign w_step    = bus.in ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
    assign w_capture = bus.enb && (r_cnt == c_CW'(R - 1));

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_int
            if (gi == 0) begin : g_first
                sd_cic_integrator #(.W(W)) u_int (
                    .clk   (clk),
                    .reset (reset),
                    .i_en  (bus.enb),
                    .i_add (w_step),
                    .o_acc (w_int[0])
                );
            end else begin : g_chain
                sd_cic_integrator #(.W(W)) u_int (
                    .clk   (clk),
                    .reset (reset),
                    .i_en  (bus.enb),
                    .i_add (w_int[gi-1]),
                    .o_acc (w_int[gi])
                );
            end
        end
    endgenerate

    // Decimation phase counter; R is a power of two so it wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (bus.enb) begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    // Comb FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Comb FSM sequencing: COMB stalls with enb, DONE always completes
    always_comb begin
        w_state_nxt = r_state;
        w_comb_step = 1'b0;
        w_emit      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = ST_COMB;
                end
            end
            ST_COMB: begin
                if (bus.enb) begin
                    w_comb_step = 1'b1;
                    if (r_k == c_KW'(N - 1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_emit      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sample capture, shared-subtractor comb stages and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x     <= '0;
            r_k     <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_d[i] <= '0;
            end
        end else begin
            r_valid <= w_emit;
            if (w_capture) begin
                r_x <= w_int[N-1];
                r_k <= '0;
            end else if (w_comb_step) begin
                r_x      <= r_x - r_d[r_k];
                r_d[r_k] <= r_x;
                r_k      <= r_k + c_KW'(1);
            end
            if (w_emit) begin
                r_out <= r_x;
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_valid;

    // A new frame must never arrive while the comb pipeline is still busy
    a_capture_idle : assert property (
        @(posedge clk) disable iff (reset) w_capture |-> (r_state == ST_IDLE)
    );

endmodule
`default_nettype wire

// File: tb/tb_sd_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_cic_decimator
// Brief    : Scoreboard bench for the CIC decimator. The reference model
//            evaluates the integrators by plain arithmetic and the combs as an
//            N-th backward difference with binomial weights.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sd_cic_decimator;
    import sd_cic_pkg::*;

    localparam int     N      = 3;
    localparam int     R      = 64;
    localparam int     W      = cic_width(N, R);
    localparam longint c_GAIN = cic_gain(N, R);

    typedef struct {
        longint val;
        int     cap_edge;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    sd_cic_if #(.W(W)) bus();

    sd_cic_decimator #(.N(N), .R(R), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     tests = 0;
    int     fails = 0;
    int     edge_no = 0;
    int     en_total = 0;
    int     en_pref [int];
    exp_t   sb [$];
    longint m_int [N];
    longint m_hist [$];
    int     m_cnt;
    int     n_pulse = 0;
    int     pulse_since_rst = 0;
    int     last_pulse_edge = -1;
    longint prev_out = 0;
    logic   chk_const = 1'b0;
    longint const_val = 0;
    exp_t   mon_e;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    function automatic longint wrapw(input longint v);
        longint m;
        m = v & ((64'sd1 <<< W) - 1);
        if (m >= (64'sd1 <<< (W - 1))) m = m - (64'sd1 <<< W);
        return m;
    endfunction

    function automatic longint binom(input int n, input int k);
        longint c;
        c = 1;
        for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
        return c;
    endfunction

    // N-th backward difference of the decimated integrator output
    function automatic longint comb_ref();
        longint acc;
        acc = 0;
        for (int j = 0; j <= N; j++) begin
            if (j % 2 == 0) acc = acc + binom(N, j) * m_hist[N - j];
            else            acc = acc - binom(N, j) * m_hist[N - j];
        end
        return wrapw(acc);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N; k++) m_int[k] = 0;
        m_cnt = 0;
        m_hist.delete();
        for (int k = 0; k < N; k++) m_hist.push_back(0);
    endfunction

    // Drive one clock worth of inputs and advance the reference model
    task automatic step(input logic en, input logic b, input logic rst);
        longint old_int [N];
        exp_t   e;
        @(negedge clk);
        reset   = rst;
        bus.enb = en;
        bus.in  = b;
        if (rst) begin
            model_reset();
            sb.delete();
        end else if (en) begin
            en_total++;
            if (m_cnt == R - 1) begin
                m_hist.push_back(m_int[N-1]);
                if (m_hist.size() > N + 1) void'(m_hist.pop_front());
                e.val      = comb_ref();
                e.cap_edge = edge_no + 1;
                sb.push_back(e);
            end
            old_int  = m_int;
            m_int[0] = wrapw(old_int[0] + (b ? 1 : -1));
            for (int k = 1; k < N; k++) m_int[k] = wrapw(old_int[k] + old_int[k-1]);
            m_cnt = (m_cnt + 1) % R;
        end
        en_pref[edge_no + 1] = en_total;
    endtask

    task automatic do_reset(input logic c, input longint cv);
        step(1'b0, 1'b0, 1'b1);
        chk_const = c;
        const_val = cv;
    endtask

    // Run 8 frames of a repeating 4-bit pattern (bit i%4 for the i-th consumed bit)
    task automatic run_pattern(input string name, input logic [3:0] pat,
                               input longint cv, input logic rnd_en);
        int   n0;
        int   consumed;
        int   guard;
        logic en;
        do_reset(1'b1, cv);
        n0       = n_pulse;
        consumed = 0;
        guard    = 0;
        while (consumed < 8 * R + N + 2 && guard < 8000) begin
            en = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
            step(en, pat[consumed % 4], 1'b0);
            if (en) consumed++;
            guard++;
        end
        step(1'b0, 1'b0, 1'b0);
        chk({name, "_pulse_count"}, n_pulse - n0, 8);
    endtask

    // Monitor: pops the scoreboard on every strobe, checks value, timing, hold
    always begin
        @(posedge clk);
        #1;
        if (reset) begin
            chk("reset_out", longint'(bus.out), 0);
            chk("reset_valid", longint'(bus.out_valid), 0);
            prev_out        = 0;
            pulse_since_rst = 0;
            last_pulse_edge = -1;
        end else if (bus.out_valid) begin
            n_pulse++;
            pulse_since_rst++;
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("sample_value", longint'(bus.out), mon_e.val);
                chk("latency_enabled", en_pref[edge_no-1] - en_pref[mon_e.cap_edge], N);
                chk("latency_edge", en_pref[edge_no-1] - en_pref[edge_no-2], 1);
            end
            if (last_pulse_edge > 0) begin
                chk("pulse_spacing", en_pref[edge_no-1] - en_pref[last_pulse_edge-1], R);
            end
            if (chk_const && pulse_since_rst >= 4) begin
                chk("full_scale", longint'(bus.out), const_val);
            end
            last_pulse_edge = edge_no;
            prev_out        = longint'(bus.out);
        end else begin
            chk("out_hold", longint'(bus.out), prev_out);
        end
    end

    initial begin : stim
        int   n0;
        int   guard;
        logic en;
        reset      = 1'b1;
        bus.enb    = 1'b0;
        bus.in     = 1'b0;
        en_pref[0] = 0;
        en_pref[1] = 0;
        model_reset();
        step(1'b0, 1'b0, 1'b1);

        run_pattern("ones",   4'b1111,  c_GAIN,     1'b0);
        run_pattern("zeros",  4'b0000, -c_GAIN,     1'b0);
        run_pattern("alt",    4'b0101,  0,          1'b0);
        run_pattern("ones75", 4'b0111,  c_GAIN / 2, 1'b0);
        run_pattern("enb50",  4'b1111,  c_GAIN,     1'b1);

        // Reset while the comb pipeline is busy: in-flight sample is dropped
        do_reset(1'b1, c_GAIN);
        for (int i = 0; i < 2 * R; i++) step(1'b1, 1'b1, 1'b0);
        guard = 0;
        while (m_cnt != 1 && guard < 2 * R) begin
            step(1'b1, 1'b1, 1'b0);
            guard++;
        end
        step(1'b1, 1'b1, 1'b1);
        chk_const = 1'b1;
        const_val = c_GAIN;

        // Reset mid-frame at cnt=30, then ones: no strobe for R+N enabled cycles
        for (int i = 0; i < 3 * R; i++) step(1'b1, 1'b1, 1'b0);
        guard = 0;
        while (m_cnt != 30 && guard < 2 * R) begin
            step(1'b1, 1'b1, 1'b0);
            guard++;
        end
        step(1'b1, 1'b1, 1'b1);
        chk_const = 1'b1;
        const_val = c_GAIN;
        n0 = n_pulse;
        for (int i = 0; i < R + N; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("no_pulse_after_reset", n_pulse - n0, 0);
        for (int i = 0; i < 6 * R; i++) step(1'b1, 1'b1, 1'b0);

        // Random bitstream with random enable
        do_reset(1'b0, 0);
        for (int i = 0; i < 500 * R; i++) begin
            en = ($urandom_range(0, 3) != 0);
            step(en, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Drain: let the last captured frame reach the output
        guard = 0;
        while (m_cnt != N + 2 && guard < 2 * R) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            guard++;
        end
        step(1'b0, 1'b0, 1'b0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
